// File: rtl/lisnoc_router_input_port_if.sv
// Link and switch side signals of one router input port.
// The master drives the link and read strobes. The slave is the input port itself.
interface lisnoc_router_input_port_if #(
    parameter int unsigned flit_width = 34,
    parameter int unsigned vchannels  = 1,
    parameter int unsigned ports      = 5
);
    logic [flit_width-1:0]           link_flit;
    logic [vchannels-1:0]            link_valid;
    logic [vchannels-1:0]            link_ready;
    logic [ports*vchannels-1:0]      switch_request;
    logic [flit_width*vchannels-1:0] switch_flit;
    logic [ports*vchannels-1:0]      switch_read;

    modport master (
        output link_flit, link_valid, switch_read,
        input  link_ready, switch_request, switch_flit
    );

    modport slave (
        input  link_flit, link_valid, switch_read,
        output link_ready, switch_request, switch_flit
    );
endinterface

// File: rtl/lisnoc_router_input_port.sv
// LISNoC router input port: each vchannel buffers link flits in a FIFO, decodes the
// header destination through a static table and holds a wormhole request to one
// output port until the packet's last flit has been read by the switch.
module lisnoc_router_input_port #(
    parameter int unsigned flit_data_width = 32,
    parameter int unsigned flit_type_width = 2,
    parameter int unsigned ph_dest_width   = 5,
    parameter int unsigned num_dests       = 32,
    parameter int unsigned ports           = 5,
    parameter logic [num_dests*ports-1:0] lookup =
        {num_dests{{{(ports-1){1'b0}}, 1'b1}}},
    parameter int unsigned vchannels       = 1,
    parameter int unsigned fifo_length     = 4
) (
    input logic                       clk,
    input logic                       rst,
    lisnoc_router_input_port_if.slave bus
);
    localparam int unsigned flit_width = flit_data_width + flit_type_width;
    localparam int unsigned ptr_w      = $clog2(fifo_length);
    localparam int unsigned cnt_w      = $clog2(fifo_length + 1);

    localparam logic [cnt_w-1:0] full_count = cnt_w'(fifo_length);
    localparam logic [ptr_w-1:0] last_ptr   = ptr_w'(fifo_length - 1);

    localparam logic [flit_type_width-1:0] type_payload = flit_type_width'(0);
    localparam logic [flit_type_width-1:0] type_header  = flit_type_width'(1);
    localparam logic [flit_type_width-1:0] type_last    = flit_type_width'(2);
    localparam logic [flit_type_width-1:0] type_single  = flit_type_width'(3);

    typedef enum logic [1:0] {StIdle, StActive, StDrop} state_t;

    for (genvar v = 0; v < vchannels; v++) begin : g_vc
        logic [flit_width-1:0]      mem_q [fifo_length];
        logic [ptr_w-1:0]           rd_ptr_q, wr_ptr_q;
        logic [cnt_w-1:0]           count_q;
        state_t                     state_q, state_d;
        logic [ports-1:0]           cur_req_q, cur_req_d;
        logic [ports-1:0]           req, entry;
        logic                       push, pop, head_valid, ready, route_ok;
        logic [flit_width-1:0]      head;
        logic [flit_type_width-1:0] head_type;
        logic [ph_dest_width-1:0]   head_dest;
        logic                       head_ends;

        // No pass-through: a full FIFO refuses even when it pops this cycle.
        assign ready      = ~rst & (count_q != full_count);
        assign push       = bus.link_valid[v] & ready;
        assign head_valid = count_q != '0;
        assign head       = mem_q[rd_ptr_q];
        assign head_type  = head[flit_width-1 -: flit_type_width];
        assign head_dest  = head[flit_data_width-1 -: ph_dest_width];
        assign head_ends  = (head_type == type_last) | (head_type == type_single);

        assign bus.link_ready[v]                         = ready;
        assign bus.switch_request[v*ports +: ports]      = req;
        assign bus.switch_flit[v*flit_width +: flit_width] = head_valid ? head : '0;

        // Destination decode; out-of-table destinations map to no port.
        always_comb begin
            entry = '0;
            if (32'(head_dest) < num_dests) begin
                entry = lookup[32'(head_dest) * ports +: ports];
            end
            route_ok = entry != '0;
        end

        // Per-vchannel packet state machine: route, forward or drop.
        always_comb begin
            state_d   = state_q;
            cur_req_d = cur_req_q;
            pop       = 1'b0;
            req       = '0;
            unique case (state_q)
                StIdle: begin
                    if (head_valid) begin
                        if (head_type == type_header || head_type == type_single) begin
                            if (route_ok) begin
                                cur_req_d = entry;
                                state_d   = StActive;
                            end else begin
                                pop = 1'b1;
                                if (head_type == type_header) begin
                                    state_d = StDrop;
                                end
                            end
                        end else begin
                            // Stray payload/last outside a packet is discarded.
                            pop = 1'b1;
                        end
                    end
                end
                StActive: begin
                    req = head_valid ? cur_req_q : '0;
                    // Several read bits at once still pop only one flit.
                    pop = |(bus.switch_read[v*ports +: ports] & req);
                    if (pop && head_ends) begin
                        state_d = StIdle;
                    end
                end
                StDrop: begin
                    pop = head_valid;
                    if (pop && head_type == type_last) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // FIFO pointers, occupancy and packet state.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_ptr_q  <= '0;
                wr_ptr_q  <= '0;
                count_q   <= '0;
                state_q   <= StIdle;
                cur_req_q <= '0;
            end else begin
                state_q   <= state_d;
                cur_req_q <= cur_req_d;
                if (push) begin
                    wr_ptr_q <= (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + ptr_w'(1);
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + ptr_w'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + cnt_w'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - cnt_w'(1);
                end
            end
        end

        // FIFO storage; push is already blocked during reset.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.link_flit;
            end
        end
    end
endmodule

// File: tb/tb_lisnoc_router_input_port.sv
// Directed bench for lisnoc_router_input_port with two vchannels and a partial lookup.
// A queue-based packet model predicts ready/request/head every cycle.
module tb_lisnoc_router_input_port;
    typedef logic [33:0] flit_t;

    localparam logic [1:0] T_PAY = 2'b00;
    localparam logic [1:0] T_HDR = 2'b01;
    localparam logic [1:0] T_LST = 2'b10;
    localparam logic [1:0] T_SGL = 2'b11;

    // dest 0->p0, 1->p1, 2->p0, 3->p2, 4->p4, 5->none, 6..15->p0
    localparam logic [16*5-1:0] LK = {{10{5'b00001}}, 5'b00000, 5'b10000, 5'b00100,
                                      5'b00001, 5'b00010, 5'b00001};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lisnoc_router_input_port_if #(.flit_width(34), .vchannels(2), .ports(5)) bus ();

    lisnoc_router_input_port #(
        .flit_data_width(32),
        .flit_type_width(2),
        .ph_dest_width  (5),
        .num_dests      (16),
        .ports          (5),
        .lookup         (LK),
        .vchannels      (2),
        .fifo_length    (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic flit_t mk(input logic [1:0] t, input logic [4:0] d,
                                 input logic [26:0] p);
        return {t, d, p};
    endfunction

    // Model: per vchannel a flit queue, a packet mode and the granted port mask.
    logic [4:0] route_of [16];
    flit_t      mq   [2][$];
    flit_t      dlog [2][$];
    int         mmode [2];   // 0 waiting for header, 1 forwarding, 2 discarding
    logic [4:0] mroute [2];
    bit         armed = 1'b0;
    bit         m_push, m_pop;
    flit_t      m_head;
    logic [1:0] m_t;
    logic [4:0] m_d, m_entry, e_req;

    initial begin
        for (int d = 0; d < 16; d++) route_of[d] = 5'b00001;
        route_of[1] = 5'b00010;
        route_of[3] = 5'b00100;
        route_of[4] = 5'b10000;
        route_of[5] = 5'b00000;
    end

    function automatic logic [4:0] exp_req(input int v);
        return (mmode[v] == 1 && mq[v].size() != 0) ? mroute[v] : 5'b0;
    endfunction

    always @(posedge clk) begin
        for (int v = 0; v < 2; v++) begin
            if (rst) begin
                mq[v].delete();
                mmode[v]  = 0;
                mroute[v] = 5'b0;
            end else begin
                m_push = bus.link_valid[v] && mq[v].size() < 4;
                m_pop  = 1'b0;
                if (mq[v].size() != 0) begin
                    m_head  = mq[v][0];
                    m_t     = m_head[33:32];
                    m_d     = m_head[31:27];
                    m_entry = (m_d < 16) ? route_of[m_d[3:0]] : 5'b0;
                    if (mmode[v] == 0) begin
                        if (m_t == T_HDR || m_t == T_SGL) begin
                            if (m_entry != 0) begin
                                mroute[v] = m_entry;
                                mmode[v]  = 1;
                            end else begin
                                m_pop = 1'b1;
                                if (m_t == T_HDR) mmode[v] = 2;
                            end
                        end else begin
                            m_pop = 1'b1;
                        end
                    end else if (mmode[v] == 1) begin
                        m_pop = (bus.switch_read[v*5 +: 5] & mroute[v]) != 0;
                        if (m_pop && (m_t == T_LST || m_t == T_SGL)) mmode[v] = 0;
                    end else begin
                        m_pop = 1'b1;
                        if (m_t == T_LST) mmode[v] = 0;
                    end
                end
                if (m_pop) void'(mq[v].pop_front());
                if (m_push) mq[v].push_back(bus.link_flit);
            end
        end
        armed = 1'b1;
    end

    // Cycle-by-cycle comparison against the model, plus a log of observed switch pops.
    always @(negedge clk) begin
        if (armed) begin
            for (int v = 0; v < 2; v++) begin
                e_req = exp_req(v);
                chk("model_ready", bus.link_ready[v], !rst && mq[v].size() < 4);
                chk("model_request", bus.switch_request[v*5 +: 5], e_req);
                if (rst) chk("model_flit_reset", bus.switch_flit[v*34 +: 34], 0);
                else if (e_req != 0) chk("model_flit", bus.switch_flit[v*34 +: 34], mq[v][0]);
                if ((bus.switch_request[v*5 +: 5] & bus.switch_read[v*5 +: 5]) != 0)
                    dlog[v].push_back(bus.switch_flit[v*34 +: 34]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] vmask, input flit_t f);
        bus.link_flit  = f;
        bus.link_valid = vmask;
        tick();
        bus.link_valid = 2'b00;
    endtask

    flit_t fl [6];
    flit_t dr [6];
    int    sent;
    bit    acc;

    initial begin
        bus.link_flit   = mk(T_HDR, 5'd3, 27'h1);
        bus.link_valid  = 2'b11;
        bus.switch_read = '0;

        // Reset held with valid asserted: nothing accepted, nothing requested.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ready", bus.link_ready, 2'b00);
            chk("rst_request", bus.switch_request, 10'b0);
        end
        rst = 1'b0;
        bus.link_valid = 2'b00;
        #1;
        chk("rst_ready_after", bus.link_ready, 2'b11);
        for (int i = 0; i < 3; i++) tick();
        chk("rst_no_push", bus.switch_request, 10'b0);

        // Single packet on vc0, dest 3 -> port 2, read held.
        bus.switch_read = 10'b0000000100;
        send(2'b01, mk(T_HDR, 5'd3, 27'h11));
        chk("sp_c1_req", bus.switch_request, 10'b0);
        send(2'b01, mk(T_PAY, 5'd0, 27'h12));
        chk("sp_c2_req", bus.switch_request, 10'b0000000100);
        chk("sp_c2_flit", bus.switch_flit[33:0], mk(T_HDR, 5'd3, 27'h11));
        send(2'b01, mk(T_LST, 5'd0, 27'h13));
        chk("sp_c3_flit", bus.switch_flit[33:0], mk(T_PAY, 5'd0, 27'h12));
        tick();
        chk("sp_c4_req", bus.switch_request, 10'b0000000100);
        chk("sp_c4_flit", bus.switch_flit[33:0], mk(T_LST, 5'd0, 27'h13));
        tick();
        chk("sp_c5_idle", bus.switch_request, 10'b0);
        bus.switch_read = '0;
        tick();

        // Backpressure: 6-flit packet with the switch stalled.
        fl[0] = mk(T_HDR, 5'd3, 27'h20);
        for (int i = 1; i < 5; i++) fl[i] = mk(T_PAY, 5'd0, 27'(32'h20 + i));
        fl[5] = mk(T_LST, 5'd0, 27'h25);
        dlog[0].delete();
        sent = 0;
        for (int c = 0; c < 8; c++) begin
            bus.link_flit  = fl[sent];
            bus.link_valid = 2'b01;
            acc = bus.link_ready[0];
            tick();
            if (acc) sent++;
        end
        chk("bp_accepted", sent, 4);
        chk("bp_ready_low", bus.link_ready[0], 1'b0);
        bus.switch_read = 10'b0000000100;
        acc = bus.link_ready[0];
        tick();
        if (acc) sent++;
        chk("bp_no_passthrough", sent, 4);
        chk("bp_ready_back", bus.link_ready[0], 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (sent < 6) begin
                bus.link_flit  = fl[sent];
                bus.link_valid = 2'b01;
                acc = bus.link_ready[0];
            end else begin
                bus.link_valid = 2'b00;
                acc = 1'b0;
            end
            tick();
            if (acc) sent++;
        end
        bus.link_valid  = 2'b00;
        bus.switch_read = '0;
        chk("bp_sent", sent, 6);
        chk("bp_popped", dlog[0].size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < dlog[0].size()) chk("bp_order", dlog[0][i], fl[i]);
        tick();

        // Unknown dest packet dropped, zero-entry SINGLE dropped, then a routed SINGLE.
        bus.switch_read = 10'b0000000010;
        dr[0] = mk(T_HDR, 5'd20, 27'h30);
        dr[1] = mk(T_PAY, 5'd0, 27'h31);
        dr[2] = mk(T_PAY, 5'd0, 27'h32);
        dr[3] = mk(T_LST, 5'd0, 27'h33);
        dr[4] = mk(T_SGL, 5'd5, 27'h34);
        dr[5] = mk(T_SGL, 5'd1, 27'h35);
        for (int i = 0; i < 6; i++) begin
            send(2'b01, dr[i]);
            chk("drop_no_request", bus.switch_request, 10'b0);
            chk("drop_ready", bus.link_ready[0], 1'b1);
        end
        tick();
        chk("drop_next_req", bus.switch_request, 10'b0000000010);
        chk("drop_next_flit", bus.switch_flit[33:0], dr[5]);
        tick();
        chk("drop_next_done", bus.switch_request, 10'b0);
        bus.switch_read = '0;
        tick();

        // Stray PAYLOAD discarded, then SINGLE to port 0.
        bus.switch_read = 10'b0000000001;
        send(2'b01, mk(T_PAY, 5'd0, 27'h40));
        chk("stray_c1", bus.switch_request, 10'b0);
        send(2'b01, mk(T_SGL, 5'd0, 27'h41));
        chk("stray_c2", bus.switch_request, 10'b0);
        tick();
        chk("single_req", bus.switch_request, 10'b0000000001);
        chk("single_flit", bus.switch_flit[33:0], mk(T_SGL, 5'd0, 27'h41));
        tick();
        chk("single_done", bus.switch_request, 10'b0);
        bus.switch_read = '0;
        tick();

        // Two vchannels: vc0 -> port 1 stalled, vc1 -> port 4 reading.
        dlog[0].delete();
        dlog[1].delete();
        bus.switch_read = 10'b1000000000;
        send(2'b01, mk(T_HDR, 5'd1, 27'h50));
        send(2'b10, mk(T_HDR, 5'd4, 27'h60));
        send(2'b10, mk(T_PAY, 5'd0, 27'h61));
        chk("vc_both_req", bus.switch_request, 10'b1000000010);
        send(2'b10, mk(T_LST, 5'd0, 27'h62));
        send(2'b01, mk(T_PAY, 5'd0, 27'h51));
        send(2'b01, mk(T_LST, 5'd0, 27'h52));
        chk("vc0_still_req", bus.switch_request, 10'b0000000010);
        chk("vc1_popped", dlog[1].size(), 3);
        chk("vc0_stalled", dlog[0].size(), 0);
        if (dlog[1].size() == 3) chk("vc1_last", dlog[1][2], mk(T_LST, 5'd0, 27'h62));
        bus.switch_read = 10'b0000000010;
        for (int i = 0; i < 4; i++) tick();
        chk("vc0_popped", dlog[0].size(), 3);
        if (dlog[0].size() == 3) chk("vc0_payload", dlog[0][1], mk(T_PAY, 5'd0, 27'h51));
        chk("vc_final_idle", bus.switch_request, 10'b0);
        bus.switch_read = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lisnoc_router_input_port.md
# lisnoc_router_input_port

Receive side of a LISNoC router link, the counterpart of the router output port. Per virtual channel it accepts flits from the upstream link with a valid/ready handshake and buffers them in a FIFO. It decodes the destination of each header flit through a static lookup table and presents the packet to the switch as a wormhole request towards exactly one output port. A switch read pops one flit, and the route is held until the packet's last flit leaves.

## Interface
- flit_data_width, 32, payload bits per flit
- flit_type_width, 2, type bits (top of flit): 2'b01 HEADER, 2'b00 PAYLOAD, 2'b10 LAST, 2'b11 SINGLE
- ph_dest_width, 5, destination field width, located at flit[flit_data_width-1 -: ph_dest_width]
- num_dests, 32, number of lookup entries
- lookup, {num_dests{5'b00001}}, num_dests*ports bits; entry d = lookup[d*ports +: ports], one-hot output port
- vchannels, 1, number of virtual channels
- ports, 5, number of router output ports
- fifo_length, 4, FIFO depth per vchannel (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- link_flit  in  flit_data_width+flit_type_width  incoming flit
- link_valid  in  vchannels  flit valid for vchannel v
- link_ready  out  vchannels  vchannel v can accept
- switch_request  out  ports*vchannels  bit v*ports+p: vchannel v requests output p
- switch_flit  out  flit_width*vchannels  head flit of vchannel v at slice v
- switch_read  in  ports*vchannels  bit v*ports+p: output p consumed vchannel v head

## Operation
- Vchannels are fully independent; each has a FIFO, a state register and a registered route cur_req[ports-1:0].
- Link write: link_valid[v] & link_ready[v] pushes link_flit into FIFO v. link_ready[v] = ~rst & (count_v < fifo_length). There is no pass-through: a full FIFO deasserts ready even if a pop happens in the same cycle.
- switch_flit slice v = FIFO v head. Its value is don't-care while no request is asserted.
- State machine per vchannel, states IDLE, ACTIVE, DROP:
  - IDLE, head valid, head type HEADER or SINGLE, dest < num_dests, lookup entry nonzero: cur_req <= entry, go to ACTIVE. Nothing is popped.
  - IDLE, head valid, header with dest >= num_dests or a zero entry: pop the head. SINGLE stays in IDLE; HEADER goes to DROP.
  - IDLE, head valid, type PAYLOAD or LAST (protocol error): pop and discard it, stay in IDLE.
  - ACTIVE: switch_request[v*ports +: ports] = head_valid ? cur_req : 0. Any bit of switch_read[v*ports +: ports] & switch_request pops one flit. Popping a LAST or SINGLE returns the state to IDLE.
  - DROP: pop one flit per cycle while head valid; popping a LAST returns the state to IDLE.
- Multiple switch_read bits in one cycle are illegal. If they occur, they are treated as a single pop.
- Simultaneous push and pop on one FIFO leaves count unchanged. FIFO pointers wrap modulo fifo_length.

## Timing
- Reset values: FIFOs empty, all states IDLE, cur_req 0, switch_request 0, switch_flit 0. link_ready is 0 while rst is high and all-ones in the first cycle after.
- Header accepted on the link at edge n is FIFO head in cycle n+1. It is decoded in IDLE during n+1, and switch_request is asserted in cycle n+2.
- In ACTIVE, switch_request follows head_valid combinationally, giving 1 flit/cycle throughput while switch_read is held high.
- Between packets there is one bubble cycle: IDLE decode after a LAST/SINGLE pop.
- SINGLE flit latency: link handshake to request = 2 cycles. Request to pop = same cycle as switch_read.
- rst mid-packet discards all buffered flits and the route. Partial packets are not recovered.

## Test plan
- Reset: hold rst 3 cycles with link_valid=1 -> link_ready=0, switch_request=0, no push. After release, link_ready=1.
- Single packet, vchannels=1, lookup dest 3 -> 5'b00100: send HEADER(dest 3), PAYLOAD, LAST back-to-back with switch_read[2] tied high -> switch_request=5'b00100 from cycle 2 through 4, flits popped in order, IDLE after LAST.
- Backpressure: fifo_length=4, switch_read=0, stream 6 flits -> link_ready drops after the 4th accept. Asserting one read re-raises ready the following cycle, with no loss or duplication.
- Unknown destination: header with dest beyond num_dests followed by 2 PAYLOAD and a LAST -> no switch_request ever. 4 pops are observed, then the next valid packet routes normally.
- Two vchannels: vc0 to port 1, vc1 to port 4, with switch_read stalled on vc0 only -> vc1 completes unaffected, request bits 1 and 9 are independent.
- Stray PAYLOAD in IDLE, then SINGLE to port 0 -> PAYLOAD is discarded and the SINGLE requests 5'b00001 two cycles after its arrival.
